// File: rtl/i2c_mst_ctrl_byte.sv
// Byte-level I2C master controller: sequences START / 8 data bits / ACK / STOP
// commands to a bit-level controller and reports completion or arbitration loss.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an accepted byte command, core_cmd = NOP
// START   | bit controller generating START condition
// WRITE   | shifting sr[7] out, one bit per core_ack, cnt counts down
// READ    | shifting core_rxd into sr[0], one bit per core_ack
// ACK     | ACK slot: read slave ACK after a write, drive ack_in after a read
// STOP    | bit controller generating STOP condition
module i2c_mst_ctrl_byte #(
  parameter logic [3:0] CMD_NOP   = 4'b0000,
  parameter logic [3:0] CMD_START = 4'b0001,
  parameter logic [3:0] CMD_STOP  = 4'b0010,
  parameter logic [3:0] CMD_WRITE = 4'b0100,
  parameter logic [3:0] CMD_READ  = 4'b1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_al,
  input  logic       core_rxd
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] core_cmd_q, core_cmd_d;
  logic       core_txd_q, core_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       al_q, al_d;
  logic       ack_out_q, ack_out_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic       go;
  logic       finish;

  assign go = ena & ~cmd_ack_q & ~al_q & (start | stop | read | write);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      core_cmd_q <= CMD_NOP;
      core_txd_q <= 1'b1;
      cmd_ack_q  <= 1'b0;
      al_q       <= 1'b0;
      ack_out_q  <= 1'b0;
      dout_q     <= 8'h00;
      sr_q       <= 8'h00;
      cnt_q      <= 3'd0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_cmd_q <= core_cmd_d;
      core_txd_q <= core_txd_d;
      cmd_ack_q  <= cmd_ack_d;
      al_q       <= al_d;
      ack_out_q  <= ack_out_d;
      dout_q     <= dout_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (core_al) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            if (start)      state_d = ST_START;
            else if (write) state_d = ST_WRITE;
            else if (read)  state_d = ST_READ;
            else            state_d = ST_STOP;
          end
        end
        ST_START: begin
          if (core_ack) begin
            if (write)     state_d = ST_WRITE;
            else if (read) state_d = ST_READ;
            else if (stop) state_d = ST_STOP;
            else           state_d = ST_IDLE;
          end
        end
        ST_WRITE, ST_READ: begin
          if (core_ack && cnt_q == 3'd0) state_d = ST_ACK;
        end
        ST_ACK: begin
          if (core_ack) state_d = stop ? ST_STOP : ST_IDLE;
        end
        ST_STOP: begin
          if (core_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Any return to IDLE that is not caused by arbitration loss completes the byte.
  assign finish = ~core_al & (state_q != ST_IDLE) & (state_d == ST_IDLE);

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    dout_d    = dout_q;
    ack_out_d = ack_out_q;
    if (!core_al) begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            sr_d  = din;
            cnt_d = 3'd7;
            rd_d  = read & ~write;
          end
        end
        ST_WRITE, ST_READ: begin
          if (core_ack) begin
            sr_d = {sr_q[6:0], (state_q == ST_READ) ? core_rxd : 1'b0};
            if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
          end
        end
        ST_ACK: begin
          if (core_ack) begin
            if (rd_q) dout_d    = sr_q;
            else      ack_out_d = core_rxd;
          end
        end
        default: ;
      endcase
    end

    case (state_d)
      ST_START: core_cmd_d = CMD_START;
      ST_WRITE: core_cmd_d = CMD_WRITE;
      ST_READ:  core_cmd_d = CMD_READ;
      ST_ACK:   core_cmd_d = rd_d ? CMD_WRITE : CMD_READ;
      ST_STOP:  core_cmd_d = CMD_STOP;
      default:  core_cmd_d = CMD_NOP;
    endcase

    core_txd_d = core_txd_q;
    if (state_d == ST_WRITE)         core_txd_d = sr_d[7];
    else if (state_d == ST_ACK && rd_d) core_txd_d = ack_in;

    cmd_ack_d = finish;
    al_d      = core_al;
  end

  assign cmd_ack  = cmd_ack_q;
  assign al       = al_q;
  assign ack_out  = ack_out_q;
  assign dout     = dout_q;
  assign core_cmd = core_cmd_q;
  assign core_txd = core_txd_q;

endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Bench for i2c_mst_ctrl_byte: a bit-controller model acks each command three
// cycles after issue; each byte's command sequence is predicted from the request flags.
module tb_i2c_mst_ctrl_byte;
  localparam logic [3:0] NOP = 4'b0000, STA = 4'b0001, STO = 4'b0010,
                         WR  = 4'b0100, RD  = 4'b1000;

  logic       clk = 1'b0, rstn = 1'b0, ena = 1'b0;
  logic       start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
  logic [7:0] din = 8'h00;
  logic       cmd_ack, ack_out, al, core_txd;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_ack = 1'b0, core_al = 1'b0, core_rxd = 1'b0;

  int checks = 0, errors = 0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ack  = 1'b0;

  always #5 clk = ~clk;

  i2c_mst_ctrl_byte dut (
    .clk(clk), .rstn(rstn), .ena(ena), .start(start), .stop(stop),
    .read(read), .write(write), .ack_in(ack_in), .din(din),
    .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout), .al(al),
    .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_al(core_al), .core_rxd(core_rxd)
  );

  logic [4:0] log_q[$];
  logic       rx_bits[$];
  int wait_cnt = 0, wr_seen = 0, al_at_write = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      core_ack = 1'b0; core_al = 1'b0; wait_cnt = 0;
    end else if (core_ack || core_al) begin
      core_ack = 1'b0; core_al = 1'b0; wait_cnt = 0;
    end else if (core_cmd != NOP) begin
      wait_cnt++;
      if (wait_cnt == 1 && core_cmd == WR) wr_seen++;
      if (wait_cnt == 2 && core_cmd == WR && wr_seen == al_at_write) begin
        core_al = 1'b1;
      end else if (wait_cnt == 3) begin
        core_ack = 1'b1;
        if (core_cmd == RD && rx_bits.size() > 0) core_rxd = rx_bits.pop_front();
        else core_rxd = 1'($urandom_range(0, 1));
        log_q.push_back({core_cmd, core_txd});
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_byte(input logic s, input logic p, input logic r, input logic w,
                         input logic [7:0] d, input logic a_in, input logic [7:0] rxb,
                         input logic sack, input int ena_hold);
    logic [4:0] exp_q[$];
    logic [3:0] first_cmd;
    bit done;
    exp_q = {};
    if (s) exp_q.push_back({STA, 1'b0});
    if (w) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({WR, d[i]});
      exp_q.push_back({RD, 1'b0});
    end else if (r) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({RD, 1'b0});
      exp_q.push_back({WR, a_in});
    end
    if (p) exp_q.push_back({STO, 1'b0});
    first_cmd = exp_q[0][4:1];

    log_q = {}; rx_bits = {};
    if (w) rx_bits.push_back(sack);
    else if (r) for (int i = 7; i >= 0; i--) rx_bits.push_back(rxb[i]);

    din = d; ack_in = a_in; start = s; stop = p; read = r; write = w;
    if (ena_hold > 0) begin
      ena = 1'b0;
      repeat (ena_hold) begin
        @(negedge clk);
        chk("ena_block_nop", core_cmd, NOP);
      end
      ena = 1'b1;
      @(negedge clk);
      chk("ena_accept", core_cmd, first_cmd);
    end else begin
      ena = 1'b1;
    end

    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ack) begin done = 1'b1; break; end
    end
    chk("cmd_ack_seen", done, 1);
    if (w) exp_ack = sack;
    else if (r) exp_dout = rxb;
    chk("dout", dout, exp_dout);
    chk("ack_out", ack_out, exp_ack);
    start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;

    chk("seq_len", log_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < log_q.size()) begin
        chk("seq_cmd", log_q[i][4:1], exp_q[i][4:1]);
        if (exp_q[i][4:1] == WR) chk("seq_txd", log_q[i][0], exp_q[i][0]);
      end
    end
    @(negedge clk);
    chk("cmd_ack_one_cycle", cmd_ack, 0);
    chk("idle_nop", core_cmd, NOP);
  endtask

  initial begin
    logic [3:0] f;
    bit got_al, saw_ack;

    repeat (2) @(negedge clk);
    chk("rst_core_cmd", core_cmd, NOP);
    chk("rst_core_txd", core_txd, 1);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_al", al, 0);
    chk("rst_ack_out", ack_out, 0);
    chk("rst_dout", dout, 8'h00);
    rstn = 1'b1;
    @(negedge clk);

    do_byte(1, 1, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
    do_byte(0, 0, 1, 0, 8'h00, 1, 8'h69, 0, 0);
    do_byte(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    // arbitration lost while the 4th data bit is on the bus
    al_at_write = 4; wr_seen = 0; log_q = {}; rx_bits = {};
    din = 8'h3C; start = 1'b1; write = 1'b1; ena = 1'b1;
    got_al = 0; saw_ack = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ack) saw_ack = 1;
      if (al) begin got_al = 1; break; end
    end
    chk("al_seen", got_al, 1);
    chk("al_core_cmd_nop", core_cmd, NOP);
    start = 1'b0; write = 1'b0;
    chk("al_seq_len", log_q.size(), 4);
    repeat (4) begin
      @(negedge clk);
      if (cmd_ack) saw_ack = 1;
      chk("al_stays_idle", core_cmd, NOP);
    end
    chk("al_one_cycle", al, 0);
    chk("al_no_cmd_ack", saw_ack, 0);
    al_at_write = 0;

    do_byte(0, 0, 0, 1, 8'h5A, 0, 8'h00, 1, 20);

    // reset in the middle of a write
    do_byte(0, 0, 1, 0, 8'h00, 0, 8'hC3, 0, 0);
    wr_seen = 0; log_q = {}; rx_bits = {};
    din = 8'h96; write = 1'b1; ena = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (wr_seen >= 5) break;
    end
    chk("rst_reach_bit5", wr_seen, 5);
    rstn = 1'b0;
    #1;
    chk("arst_core_cmd", core_cmd, NOP);
    chk("arst_core_txd", core_txd, 1);
    chk("arst_cmd_ack", cmd_ack, 0);
    chk("arst_al", al, 0);
    chk("arst_ack_out", ack_out, 0);
    chk("arst_dout", dout, 8'h00);
    write = 1'b0; exp_dout = 8'h00; exp_ack = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    saw_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmd_ack) saw_ack = 1;
    end
    chk("arst_no_cmd_ack", saw_ack, 0);
    do_byte(0, 0, 0, 1, 8'hFF, 0, 8'h00, 1, 0);

    for (int t = 0; t < 12; t++) begin
      f = 4'($urandom_range(1, 15));
      do_byte(f[0], f[1], f[2], f[3], 8'($urandom), 1'($urandom_range(0, 1)),
              8'($urandom), 1'($urandom_range(0, 1)), (t % 4 == 0) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
